// File: rtl/aes_enc_iter.sv
// Iterative AES-128/192/256 encryption core: one round per clock, round keys
// supplied externally per rk_idx, IDLE/RUN/DONE control with ready/valid handshakes.
`timescale 1ns/1ps
module aes_enc_iter #(
  parameter int NR_MAX = 14
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   mode,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data_in,
  output logic [3:0]   rk_idx,
  input  logic [127:0] round_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out,
  output logic         busy
);

  localparam logic [3:0] NR_CAP = 4'(NR_MAX);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  function automatic logic [7:0] sbox_byte(input logic [7:0] x);
    return SBOX[2047 - 8*int'(x) -: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] aes_sbox_128(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox_byte(s[8*i +: 8]);
    return o;
  endfunction

  // Byte n = row + 4*col, byte 0 in the top bits; row r rotates left by r columns.
  function automatic logic [127:0] aes_shiftrow(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c + r) % 4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] aes_mixcols(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = s[127 - 32*c -: 32];
      o[127 - 32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                             a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                             a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                             xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    end
    return o;
  endfunction

  function automatic logic [127:0] aes_addroundkey(input logic [127:0] s, input logic [127:0] k);
    return s ^ k;
  endfunction

  state_t       r_fsm;
  logic [3:0]   r_round;
  logic [1:0]   r_mode;
  logic [127:0] r_state;
  logic         r_in_ready;
  logic         r_out_valid;
  logic         r_busy;

  logic [3:0]   w_nr_raw;
  logic [3:0]   w_nr;
  logic         w_last;
  logic [127:0] w_sr;
  logic [127:0] w_mc;
  logic [127:0] w_next;

  always_comb begin
    case (r_mode)
      2'b00:   w_nr_raw = 4'd10;
      2'b01:   w_nr_raw = 4'd12;
      default: w_nr_raw = 4'd14;
    endcase
    w_nr   = (w_nr_raw > NR_CAP) ? NR_CAP : w_nr_raw;
    w_last = (r_round == w_nr);
    w_sr   = aes_shiftrow(aes_sbox_128(r_state));
    w_mc   = aes_mixcols(w_sr);
    w_next = aes_addroundkey(w_last ? w_sr : w_mc, round_key);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fsm       <= S_IDLE;
      r_round     <= 4'd0;
      r_mode      <= 2'b00;
      r_state     <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_fsm)
        S_IDLE: begin
          r_in_ready <= 1'b1;
          if (in_valid && r_in_ready) begin
            r_state    <= aes_addroundkey(data_in, round_key);
            r_mode     <= mode;
            r_round    <= 4'd1;
            r_fsm      <= S_RUN;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        S_RUN: begin
          r_state <= w_next;
          if (w_last) begin
            r_fsm       <= S_DONE;
            r_out_valid <= 1'b1;
          end else begin
            r_round <= r_round + 4'd1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_fsm       <= S_IDLE;
            r_round     <= 4'd0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: r_fsm <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign rk_idx    = r_round;
  // The state register only leaves the block once the final round is in it.
  assign data_out  = r_out_valid ? r_state : '0;

endmodule

// File: tb/tb_aes_enc_iter.sv
// Bench for aes_enc_iter: byte-level AES reference with computed S-box and key
// expansion, per-cycle output model, FIPS-197 vectors, backpressure, reset abort, random stream.
`timescale 1ns/1ps
module tb_aes_enc_iter;

  typedef logic [14:0][127:0] rks_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   mode;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] data_in;
  logic [3:0]   rk_idx;
  logic [127:0] round_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] data_out;
  logic         busy;

  aes_enc_iter #(.NR_MAX(14)) dut (
    .clk(clk), .reset(reset), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .rk_idx(rk_idx), .round_key(round_key), .out_valid(out_valid),
    .out_ready(out_ready), .data_out(data_out), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]   sb [0:255];
  rks_t         rk_tab;
  logic [255:0] cur_key;

  always_comb round_key = (rk_idx <= 4'd14) ? rk_tab[rk_idx] : '0;

  localparam logic [255:0] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT2  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT3  = 128'h8ea2b7ca516745bfeafc49904b496089;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rol8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  function automatic int nr_of(input logic [1:0] md);
    return (md == 2'b00) ? 10 : (md == 2'b01) ? 12 : 14;
  endfunction

  function automatic rks_t key_expand(input logic [255:0] key, input logic [1:0] md);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rc;
    rks_t        rks;
    int          nk, nr;
    nr = nr_of(md); nk = nr - 6; rc = 8'h01; rks = '0;
    for (int i = 0; i < 60; i++) w[i] = 32'h0;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
    for (int i = nk; i < 4*(nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = subword(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) rks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return rks;
  endfunction

  function automatic logic [127:0] aes_ref(input logic [255:0] key, input logic [1:0] md, input logic [127:0] pt);
    rks_t       rks;
    logic [7:0] st [16];
    logic [7:0] t  [16];
    logic [7:0] m0, m1, m2, m3;
    logic [127:0] res;
    int nr;
    rks = key_expand(key, md); nr = nr_of(md);
    for (int i = 0; i < 16; i++) st[i] = pt[127 - 8*i -: 8] ^ rks[0][127 - 8*i -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sb[st[i]];
      for (int i = 0; i < 16; i++) st[i] = t[(i % 4) + 4*(((i / 4) + (i % 4)) % 4)];
      if (r != nr) begin
        for (int c = 0; c < 4; c++) begin
          m0 = st[4*c]; m1 = st[4*c+1]; m2 = st[4*c+2]; m3 = st[4*c+3];
          st[4*c]   = gmul(m0, 8'h02) ^ gmul(m1, 8'h03) ^ m2 ^ m3;
          st[4*c+1] = m0 ^ gmul(m1, 8'h02) ^ gmul(m2, 8'h03) ^ m3;
          st[4*c+2] = m0 ^ m1 ^ gmul(m2, 8'h02) ^ gmul(m3, 8'h03);
          st[4*c+3] = gmul(m0, 8'h03) ^ m1 ^ m2 ^ gmul(m3, 8'h02);
        end
      end
      for (int i = 0; i < 16; i++) st[i] = st[i] ^ rks[r][127 - 8*i -: 8];
    end
    for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = st[i];
    return res;
  endfunction

  // Per-cycle expectation of the DUT outputs, advanced from the inputs seen before each edge.
  logic         m_known = 1'b0;
  logic         m_infl  = 1'b0;
  logic         m_ir    = 1'b0;
  int           m_e     = 0;
  int           m_nr    = 10;
  logic [127:0] m_exp   = '0;
  int           n_acc   = 0;
  int           n_hs    = 0;
  int           cyc     = 0;
  int           last_acc = 0;
  int           last_gap = 0;

  always @(negedge clk) begin
    logic vld;
    int   exp_rk;
    cyc++;
    vld = m_infl && (m_e >= m_nr);
    if (m_known) begin
      exp_rk = m_infl ? ((m_e + 1 < m_nr) ? m_e + 1 : m_nr) : 0;
      chk("in_ready", 128'(in_ready), 128'(m_ir));
      chk("busy", 128'(busy), 128'(m_infl));
      chk("out_valid", 128'(out_valid), 128'(vld));
      chk("data_out", data_out, vld ? m_exp : 128'h0);
      chk("rk_idx", 128'(rk_idx), 128'(exp_rk));
    end
    if (reset) begin
      m_known = 1'b1; m_infl = 1'b0; m_ir = 1'b0;
    end else if (m_known) begin
      if (!m_infl) begin
        if (in_valid && m_ir) begin
          m_infl = 1'b1; m_e = 0; m_ir = 1'b0; m_nr = nr_of(mode);
          m_exp = aes_ref(cur_key, mode, data_in);
          n_acc++;
          last_gap = cyc - last_acc; last_acc = cyc;
        end else begin
          m_ir = 1'b1;
        end
      end else if (vld && out_ready) begin
        m_infl = 1'b0; m_ir = 1'b1; n_hs++;
      end else begin
        m_e++;
      end
    end
  end

  task automatic send(input logic [255:0] key, input logic [1:0] md, input logic [127:0] pt,
                      input int low, output logic [127:0] ct, output int lat);
    logic acc;
    int   n;
    logic [127:0] held;
    rk_tab = key_expand(key, md); cur_key = key;
    data_in = pt; mode = md; in_valid = 1'b1; out_ready = 1'b0;
    acc = 1'b0; n = 0; ct = '0; lat = 0;
    while (!acc && n < 40) begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #2; n++;
    end
    chk("accept_wait", 128'(acc), 128'h1);
    if (!acc) return;
    in_valid = 1'b0; data_in = {$urandom, $urandom, $urandom, $urandom}; mode = 2'($urandom);
    while (lat < 40) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk); #2; lat++;
    end
    held = data_out; ct = held;
    @(posedge clk); #2;
    for (int i = 0; i < low; i++) begin
      in_valid = 1'($urandom); mode = 2'($urandom); data_in = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      chk("bp_data_out", data_out, held);
      chk("bp_in_ready", 128'(in_ready), 128'h0);
      @(posedge clk); #2;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #2;
    out_ready = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]   inv, b;
    logic [127:0] ct;
    logic [255:0] key;
    logic [1:0]   md;
    logic         acc, hs, fast;
    int           lat, n, acc0, hs0;

    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv;
      sb[x] = b ^ rol8(b, 1) ^ rol8(b, 2) ^ rol8(b, 3) ^ rol8(b, 4) ^ 8'h63;
    end

    reset = 1'b1; mode = 2'b00; in_valid = 1'b0; data_in = '0; out_ready = 1'b0;
    rk_tab = '0; cur_key = '0;

    chk("model_c1", aes_ref(K128, 2'b00, PT), CT1);
    chk("model_c2", aes_ref(K192, 2'b01, PT), CT2);
    chk("model_c3", aes_ref(K256, 2'b10, PT), CT3);

    repeat (3) @(posedge clk);
    #2;
    @(negedge clk);
    chk("rst_in_ready", 128'(in_ready), 128'h0);
    chk("rst_busy", 128'(busy), 128'h0);
    chk("rst_out_valid", 128'(out_valid), 128'h0);
    chk("rst_data_out", data_out, 128'h0);
    chk("rst_rk_idx", 128'(rk_idx), 128'h0);
    @(posedge clk); #2;
    reset = 1'b0;
    @(posedge clk); #2;
    @(negedge clk);
    chk("post_rst_in_ready", 128'(in_ready), 128'h1);
    @(posedge clk); #2;

    send(K128, 2'b00, PT, 0, ct, lat);
    chk("c1_ct", ct, CT1);
    chk("c1_latency", 128'(lat), 128'd10);
    send(K192, 2'b01, PT, 0, ct, lat);
    chk("c2_ct", ct, CT2);
    chk("c2_latency", 128'(lat), 128'd12);
    send(K256, 2'b10, PT, 5, ct, lat);
    chk("c3_ct", ct, CT3);
    chk("c3_latency", 128'(lat), 128'd14);
    send(K256, 2'b11, PT, 0, ct, lat);
    chk("c3_mode11_ct", ct, CT3);
    chk("c3_mode11_latency", 128'(lat), 128'd14);

    // Abort an AES-256 block while rk_idx is 5.
    rk_tab = key_expand(K256, 2'b10); cur_key = K256;
    data_in = PT; mode = 2'b10; in_valid = 1'b1;
    acc = 1'b0; n = 0;
    while (!acc && n < 40) begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #2; n++;
    end
    chk("abort_accept", 128'(acc), 128'h1);
    in_valid = 1'b0;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      if (rk_idx == 4'd4) break;
      @(posedge clk); #2; n++;
    end
    @(posedge clk); #2;
    chk("abort_at_round5", 128'(rk_idx), 128'd5);
    reset = 1'b1;
    @(posedge clk); #2;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_out_valid", 128'(out_valid), 128'h0);
    chk("abort_busy", 128'(busy), 128'h0);
    chk("abort_in_ready", 128'(in_ready), 128'h0);
    chk("abort_data_out", data_out, 128'h0);
    chk("abort_rk_idx", 128'(rk_idx), 128'h0);
    @(posedge clk); #2;
    send(K128, 2'b00, PT, 0, ct, lat);
    chk("after_abort_c1_ct", ct, CT1);

    acc0 = n_acc; hs0 = n_hs;
    for (int blk = 0; blk < 1000; blk++) begin
      fast = (blk < 4);
      key  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      md   = fast ? 2'b00 : 2'($urandom);
      rk_tab = key_expand(key, md); cur_key = key;
      data_in = {$urandom, $urandom, $urandom, $urandom}; mode = md; in_valid = 1'b1;
      out_ready = fast ? 1'b1 : 1'($urandom);
      acc = 1'b0; n = 0;
      while (!acc && n < 40) begin
        @(negedge clk); acc = in_ready;
        @(posedge clk); #2; n++;
      end
      if (!acc) begin
        chk("stream_accept", 128'(acc), 128'h1);
        break;
      end
      hs = 1'b0; n = 0;
      while (!hs && n < 200) begin
        in_valid = 1'($urandom); mode = 2'($urandom); data_in = {$urandom, $urandom, $urandom, $urandom};
        out_ready = fast ? 1'b1 : 1'($urandom);
        @(negedge clk); hs = out_valid && out_ready;
        @(posedge clk); #2; n++;
      end
      if (!hs) begin
        chk("stream_handshake", 128'(hs), 128'h1);
        break;
      end
      if (blk == 3) chk("throughput_gap", 128'(last_gap), 128'd12);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #2;
    chk("stream_accepts", 128'(n_acc - acc0), 128'd1000);
    chk("stream_outputs", 128'(n_hs - hs0), 128'd1000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
